vppm_transmitter: RTL and testbench
===================================

VPPM_TRANSMITTER -- requirements
Module: vppm_transmitter

Interface
REQ-001 SHALL have parameter SYM_LEN, default 100, meaning clocks per VPPM symbol (legal range 4..4096).
REQ-002 SHALL have parameter PRE_LEN, default 4, meaning preamble symbols per frame (even, at least 2).
REQ-003 SHALL have parameter DATA_W, default 8, meaning payload bits per frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port tx_data, input, DATA_W bits: payload, sent MSB first.
REQ-007 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-008 SHALL have port tx_ready, output, 1 bit: the block accepts a frame this cycle.
REQ-009 SHALL have port dim_base, input, 12 bits unsigned: nominal pulse width in clocks.
REQ-010 SHALL have port dim_trim, input, 12 bits signed two's complement: pulse-width correction in clocks.
REQ-011 SHALL have port vppm_out, output, 1 bit: registered optical drive.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-014 SHALL use states IDLE, PREAMBLE and DATA.
REQ-015 SHALL transitions:
- IDLE -> PREAMBLE on tx_valid and tx_ready.
- PREAMBLE -> DATA after PRE_LEN symbols.
- DATA -> IDLE after DATA_W symbols.
REQ-016 SHALL drive tx_ready high only in IDLE, and busy high only in PREAMBLE or DATA.
REQ-017 SHALL, on acceptance, latch tx_data into a shift register, reset the symbol counter sc to 0, and reset the symbol index to 0.
REQ-018 SHALL count sc from 0 to SYM_LEN-1, then wrap to 0 and advance the symbol index (bit index).
REQ-019 SHALL compute the effective width W on acceptance and hold it for the whole frame:
- sum = zero-extended dim_base + sign-extended dim_trim, in 14-bit signed arithmetic;
- W = sum, saturated to the range [1, SYM_LEN-1];
- changes to dim_base or dim_trim mid-frame SHALL be ignored.
REQ-020 SHALL encode each symbol as follows:
- bit 0: high for sc < W;
- bit 1: high for sc >= SYM_LEN-W;
- otherwise low.
REQ-021 SHALL use the preamble pattern 1,0,1,0,... (PRE_LEN symbols), followed by the payload MSB first.
REQ-022 SHALL register vppm_out, so that it reflects the state and sc of the previous cycle; vppm_out SHALL be low whenever the previous state was IDLE.
REQ-023 SHALL pulse tx_done in the cycle after the last data symbol reaches sc = SYM_LEN-1; that same cycle SHALL be IDLE with tx_ready high.
REQ-024 SHALL make the frame last exactly (PRE_LEN+DATA_W)*SYM_LEN busy cycles.
REQ-025 SHALL, with tx_valid held high, accept the next frame in the first IDLE cycle, giving exactly one non-busy cycle between frames.
REQ-026 SHALL keep vppm_out average duty equal to W/SYM_LEN for every symbol, independent of the data.

Reset
REQ-027 SHALL, on rst high at a clock edge, set:
- state = IDLE;
- sc = 0 and symbol index = 0;
- W = 1;
- vppm_out = 0, busy = 0, tx_done = 0;
- tx_ready = 0 while rst is high, 1 in the cycle after rst is released.
REQ-028 SHALL abort any frame in progress on rst, with no tx_done for the aborted frame.
REQ-029 SHALL give rst priority over a simultaneous tx_valid; no frame is accepted in that cycle.

Structure
REQ-030 SHALL place the state encoding, PRE_PATTERN and the 14-bit width-sum width constant in shared package vppm_pkg, which the receiver also uses.
REQ-031 SHALL implement the REQ-019 saturating signed add in one combinational sub-module, vppm_width_calc.
REQ-032 SHALL hold all other logic (FSM, counters, shift register, output register) in vppm_transmitter.

Verification
REQ-033 Width from a negative trim: dim_base=200, dim_trim=-150, tx_data=8'h80, SYM_LEN=100 -> W=50; the first data symbol (bit 1) is high at sc 50..99, and the remaining data symbols are high at sc 0..49.
REQ-034 Saturation, both ends:
- dim_base=200, dim_trim=-200 -> W=1 (single-clock pulses);
- dim_base=4095, dim_trim=+2047 -> W=99.
REQ-035 Frame timing: accept tx_data=8'hA5 -> busy high for 1200 cycles, tx_done pulses exactly once, and the decoded symbols are 1010 followed by 10100101.
REQ-036 Back-to-back: tx_valid held high for two frames -> exactly one cycle with busy=0 and tx_ready=1 between the frames.
REQ-037 Reset mid-frame: assert rst at cycle 500 of a frame -> next cycle state is IDLE, vppm_out=0, busy=0, and no tx_done is issued.
REQ-038 Mid-frame dimming change: change dim_trim during a frame -> W unchanged until the next acceptance.

Source files
------------

// File: rtl/vppm_pkg.sv
// Shared VPPM definitions: FSM state encoding, preamble pattern and arithmetic widths.
// Used by both the transmitter and the receiver.
package vppm_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2
   } vppm_state_e;

   // Signed width of the base+trim sum; wide enough for 4095 + 2047 with a sign bit.
   localparam int SUM_W = 14;

   // Width of the in-symbol counter and of the effective pulse width.
   localparam int CNT_W = 12;

   // Indexed by the LSB of the preamble symbol index, giving 1,0,1,0,...
   localparam logic [1:0] PRE_PATTERN = 2'b01;

endpackage

// File: rtl/vppm_width_calc.sv
// Effective VPPM pulse width: zero-extended base plus sign-extended trim,
// saturated so that every symbol keeps at least one high and one low clock.
module vppm_width_calc
   import vppm_pkg::*;
#(
   parameter int SYM_LEN = 100
) (
   input  logic [11:0]      dim_base_i,
   input  logic [11:0]      dim_trim_i,
   output logic [CNT_W-1:0] width_o
);

   localparam logic signed [SUM_W-1:0] MAX_W = SUM_W'(SYM_LEN - 1);
   localparam logic signed [SUM_W-1:0] MIN_W = SUM_W'(1);

   logic signed [SUM_W-1:0] sum;

   always_comb begin
      sum = $signed({2'b00, dim_base_i}) + $signed({{2{dim_trim_i[11]}}, dim_trim_i});
      if (sum < MIN_W) begin
         width_o = CNT_W'(1);
      end else if (sum > MAX_W) begin
         width_o = CNT_W'(SYM_LEN - 1);
      end else begin
         width_o = sum[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/vppm_transmitter.sv
// VPPM frame transmitter: sends an alternating preamble followed by the payload
// MSB first, each symbol a pulse of width W placed early (bit 0) or late (bit 1).
module vppm_transmitter
   import vppm_pkg::*;
#(
   parameter int SYM_LEN = 100,
   parameter int PRE_LEN = 4,
   parameter int DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [11:0]       dim_base,
   input  logic [11:0]       dim_trim,
   output logic              vppm_out,
   output logic              busy,
   output logic              tx_done
);

   localparam int IDX_MAX = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
   localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

   localparam logic [CNT_W-1:0] SC_LAST   = CNT_W'(SYM_LEN - 1);
   localparam logic [CNT_W-1:0] SYM_LEN_C = CNT_W'(SYM_LEN);
   localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_LEN - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);

   vppm_state_e       state_q, state_d;
   logic [CNT_W-1:0]  sc_q, sc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  w_q, w_d;
   logic              vppm_q, vppm_d;
   logic              done_q, done_d;

   logic [CNT_W-1:0]  wCalc;
   logic [CNT_W-1:0]  hiStart;
   logic              accept;
   logic              symEnd;
   logic              symBit;
   logic              pulse;

   vppm_width_calc #(
      .SYM_LEN(SYM_LEN)
   ) u_width_calc (
      .dim_base_i(dim_base),
      .dim_trim_i(dim_trim),
      .width_o   (wCalc)
   );

   assign tx_ready = (state_q == IDLE) && !rst;
   assign accept   = tx_valid && tx_ready;
   assign busy     = (state_q != IDLE);
   assign vppm_out = vppm_q;
   assign tx_done  = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sc_q    <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         w_q     <= CNT_W'(1);
         vppm_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         w_q     <= w_d;
         vppm_q  <= vppm_d;
         done_q  <= done_d;
      end
   end

   // Late-pulse start wraps modulo 2^CNT_W, which stays exact when SYM_LEN is 4096.
   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      w_d     = w_q;
      done_d  = 1'b0;

      symEnd  = (sc_q == SC_LAST);
      hiStart = SYM_LEN_C - w_q;
      symBit  = (state_q == DATA) ? shift_q[DATA_W-1] : PRE_PATTERN[idx_q[0]];
      pulse   = symBit ? (sc_q >= hiStart) : (sc_q < w_q);
      vppm_d  = (state_q != IDLE) && pulse;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = PREAMBLE;
               sc_d    = '0;
               idx_d   = '0;
               shift_d = tx_data;
               w_d     = wCalc;
            end
         end
         PREAMBLE: begin
            sc_d = symEnd ? '0 : sc_q + CNT_W'(1);
            if (symEnd) begin
               if (idx_q == PRE_LAST) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DATA: begin
            sc_d = symEnd ? '0 : sc_q + CNT_W'(1);
            if (symEnd) begin
               shift_d = shift_q << 1;
               if (idx_q == DATA_LAST) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_vppm_transmitter.sv
// Self-checking bench for vppm_transmitter: directed and random frames compared
// against a symbol-level model of the VPPM waveform.
module tb_vppm_transmitter;

   localparam int SYM   = 100;
   localparam int PRE   = 4;
   localparam int DW    = 8;
   localparam int NSYM  = PRE + DW;
   localparam int FRAME = NSYM * SYM;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [11:0]   dim_base;
   logic [11:0]   dim_trim;
   logic          vppm_out;
   logic          busy;
   logic          tx_done;

   int checkCnt = 0;
   int passCnt  = 0;
   int failCnt  = 0;

   always #5 clk = ~clk;

   vppm_transmitter #(
      .SYM_LEN(SYM),
      .PRE_LEN(PRE),
      .DATA_W (DW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .dim_base(dim_base),
      .dim_trim(dim_trim),
      .vppm_out(vppm_out),
      .busy    (busy),
      .tx_done (tx_done)
   );

   // Compare one observed value with its model value and tally the outcome.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCnt++;
      assert (observed === expected) passCnt++;
      else begin
         failCnt++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive the frame request inputs.
   task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                                input logic [11:0] base, input logic [11:0] trim);
      tx_valid = valid;
      tx_data  = data;
      dim_base = base;
      dim_trim = trim;
   endtask

   // Reference pulse width: base + signed trim, clamped to [1, SYM-1].
   function automatic int modelWidth(input logic [11:0] base, input logic [11:0] trim);
      int s;
      s = int'(base) + int'($signed(trim));
      if (s < 1) s = 1;
      if (s > SYM - 1) s = SYM - 1;
      return s;
   endfunction

   // Run one frame from acceptance; abortAt >= 0 asserts rst at that busy cycle.
   task automatic runFrame(input string name, input logic [DW-1:0] data, input logic [11:0] base,
                           input logic [11:0] trim, input bit holdValid, input int abortAt);
      logic            wave[FRAME];
      logic [NSYM-1:0] expBits;
      logic [NSYM-1:0] gotBits;
      logic            expLvl;
      int              w;
      int              busyLow;
      int              doneCnt;
      int              waveErr;
      int              dutyErr;
      int              hc;

      w = modelWidth(base, trim);
      for (int i = 0; i < PRE; i++) expBits[NSYM-1-i] = (i % 2 == 0);
      expBits[DW-1:0] = data;

      checkOutput({name, "_ready_before"}, tx_ready, 1);
      applyStimulus(1'b1, data, base, trim);
      @(negedge clk);
      if (!holdValid) tx_valid = 1'b0;

      busyLow = 0;
      doneCnt = 0;
      for (int k = 0; k < FRAME; k++) begin
         if (k == abortAt) begin
            rst = 1'b1;
            @(negedge clk);
            checkOutput({name, "_abort_busy"}, busy, 0);
            checkOutput({name, "_abort_vppm"}, vppm_out, 0);
            checkOutput({name, "_abort_done"}, tx_done, 0);
            checkOutput({name, "_abort_ready_in_rst"}, tx_ready, 0);
            rst = 1'b0;
            for (int j = 0; j < FRAME; j++) begin
               @(negedge clk);
               if (busy) busyLow++;
               if (tx_done) doneCnt++;
            end
            checkOutput({name, "_abort_stays_idle"}, busyLow, 0);
            checkOutput({name, "_abort_no_done"}, doneCnt, 0);
            checkOutput({name, "_abort_ready_after"}, tx_ready, 1);
            return;
         end
         if (k == FRAME / 3) begin
            dim_base = 12'($urandom);
            dim_trim = 12'($urandom);
         end
         if (!busy) busyLow++;
         if (tx_done) doneCnt++;
         if (k == 0) checkOutput({name, "_vppm_first_low"}, vppm_out, 0);
         else wave[k-1] = vppm_out;
         @(negedge clk);
      end
      wave[FRAME-1] = vppm_out;

      checkOutput({name, "_busy_cycles_low"}, busyLow, 0);
      checkOutput({name, "_done_early"}, doneCnt, 0);
      checkOutput({name, "_end_busy"}, busy, 0);
      checkOutput({name, "_end_done"}, tx_done, 1);
      checkOutput({name, "_end_ready"}, tx_ready, 1);

      waveErr = 0;
      dutyErr = 0;
      for (int s = 0; s < NSYM; s++) begin
         hc = 0;
         for (int c = 0; c < SYM; c++) begin
            expLvl = expBits[NSYM-1-s] ? (c >= SYM - w) : (c < w);
            if (wave[s*SYM+c] !== expLvl) waveErr++;
            if (wave[s*SYM+c] === 1'b1) hc++;
         end
         if (hc != w) dutyErr++;
         gotBits[NSYM-1-s] = wave[s*SYM+SYM-1];
      end
      checkOutput({name, "_wave_errors"}, waveErr, 0);
      checkOutput({name, "_duty_errors"}, dutyErr, 0);
      checkOutput({name, "_decoded"}, 32'(gotBits), 32'(expBits));
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, '0, 12'd0, 12'd0);
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", tx_ready, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_vppm", vppm_out, 0);
      checkOutput("reset_done", tx_done, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("release_ready", tx_ready, 1);
      checkOutput("release_busy", busy, 0);

      rst = 1'b1;
      applyStimulus(1'b1, 8'h3C, 12'd100, 12'd0);
      @(negedge clk);
      checkOutput("rst_prio_busy", busy, 0);
      checkOutput("rst_prio_ready", tx_ready, 0);
      rst = 1'b0;
      tx_valid = 1'b0;
      @(negedge clk);
      checkOutput("rst_prio_busy_after", busy, 0);

      runFrame("negtrim", 8'h80, 12'd200, 12'(-150), 1'b0, -1);
      runFrame("sat_lo", 8'($urandom), 12'd200, 12'(-200), 1'b0, -1);
      runFrame("sat_hi", 8'($urandom), 12'd4095, 12'd2047, 1'b0, -1);
      runFrame("a5", 8'hA5, 12'd30, 12'd5, 1'b0, -1);
      runFrame("b2b_first", 8'($urandom), 12'($urandom_range(0, 120)), 12'($urandom), 1'b1, -1);
      runFrame("b2b_second", 8'($urandom), 12'($urandom_range(0, 120)), 12'($urandom), 1'b0, -1);
      runFrame("abort", 8'h5A, 12'd40, 12'd0, 1'b0, 500);
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         runFrame($sformatf("rand%0d", r), 8'($urandom), 12'($urandom_range(0, 4095)),
                  12'($urandom), 1'b0, -1);
      end

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
